// File: rtl/trng_entropy_collector_if.sv
// Word/block handshake bundle between the entropy source, the collector and the mixer.
// The master modport is the collector side; the slave modport is the source/mixer side.
interface trng_entropy_collector_if #(
   parameter int NUM_WORDS = 16
);
   logic                      src_syn;
   logic [31:0]               src_data;
   logic                      src_ack;
   logic                      block_valid;
   logic [NUM_WORDS*32-1:0]   block;
   logic                      block_ack;

   modport master (
      input  src_syn,
      input  src_data,
      input  block_ack,
      output src_ack,
      output block_valid,
      output block
   );

   modport slave (
      output src_syn,
      output src_data,
      output block_ack,
      input  src_ack,
      input  block_valid,
      input  block
   );
endinterface

// File: rtl/trng_entropy_collector.sv
// Packs 32-bit entropy words into NUM_WORDS-word blocks for the mixer.
// Define TRNG_ENTROPY_COLLECTOR_RCT_EN to add the repetition-count health test.
module trng_entropy_collector #(
   parameter int NUM_WORDS = 16,
   parameter int RCT_LIMIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic busy,
   output logic rct_error,
   trng_entropy_collector_if.master bus
);

   localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int BW = NUM_WORDS * 32;
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
`ifdef TRNG_ENTROPY_COLLECTOR_RCT_EN
      FULL,
      ERROR
`else
      FULL
`endif
   } state_t;

   state_t          state;
   logic [CW-1:0]   word_ctr;
   logic            ack_r;
   logic            valid_r;
   logic [BW-1:0]   block_r;
   logic            capture;

   // A word is only taken when the previous acknowledge has already dropped.
   assign capture = (state == COLLECT) && bus.src_syn && !ack_r;

   assign bus.src_ack     = ack_r;
   assign bus.block_valid = valid_r;
   assign bus.block       = block_r;

`ifdef TRNG_ENTROPY_COLLECTOR_RCT_EN
   localparam logic [7:0] RCT_LIM = 8'(RCT_LIMIT);

   logic [31:0] prev_word;
   logic [7:0]  rct_ctr;
   logic [7:0]  rct_next;
   logic        rct_trip;
   logic        rct_err_r;

   always_comb begin
      rct_next = ((bus.src_data == prev_word) && (rct_ctr != 8'd0)) ? rct_ctr + 8'd1 : 8'd1;
      rct_trip = capture && (rct_next == RCT_LIM);
   end

   assign rct_error = rct_err_r;
`else
   assign rct_error = 1'b0;
`endif

   // Dropping enable wins over everything, including a same-cycle block_ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         word_ctr <= '0;
         ack_r    <= 1'b0;
         valid_r  <= 1'b0;
         block_r  <= '0;
`ifdef TRNG_ENTROPY_COLLECTOR_RCT_EN
         prev_word <= '0;
         rct_ctr   <= '0;
         rct_err_r <= 1'b0;
`endif
      end else if (!enable) begin
         state    <= IDLE;
         busy     <= 1'b0;
         word_ctr <= '0;
         ack_r    <= 1'b0;
         valid_r  <= 1'b0;
         block_r  <= '0;
`ifdef TRNG_ENTROPY_COLLECTOR_RCT_EN
         prev_word <= '0;
         rct_ctr   <= '0;
         rct_err_r <= 1'b0;
`endif
      end else begin
         ack_r <= capture;
         case (state)
            IDLE: begin
               state    <= COLLECT;
               busy     <= 1'b1;
               word_ctr <= '0;
            end
            COLLECT: begin
               if (capture) begin
                  block_r <= {block_r[BW-33:0], bus.src_data};
                  if (word_ctr == LAST_IDX) begin
                     state    <= FULL;
                     valid_r  <= 1'b1;
                     word_ctr <= '0;
                  end else begin
                     word_ctr <= word_ctr + 1'b1;
                  end
`ifdef TRNG_ENTROPY_COLLECTOR_RCT_EN
                  prev_word <= bus.src_data;
                  rct_ctr   <= rct_next;
                  // A stuck source overrides block completion and wipes the partial block.
                  if (rct_trip) begin
                     state     <= ERROR;
                     busy      <= 1'b0;
                     valid_r   <= 1'b0;
                     word_ctr  <= '0;
                     block_r   <= '0;
                     rct_err_r <= 1'b1;
                  end
`endif
               end
            end
            FULL: begin
               if (bus.block_ack) begin
                  state   <= COLLECT;
                  valid_r <= 1'b0;
               end
            end
`ifdef TRNG_ENTROPY_COLLECTOR_RCT_EN
            ERROR: begin
               busy    <= 1'b0;
               valid_r <= 1'b0;
            end
`endif
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trng_entropy_collector.sv
// Directed test of trng_entropy_collector with NUM_WORDS=16 and RCT_LIMIT=4.
// The health-test scenario follows TRNG_ENTROPY_COLLECTOR_RCT_EN as the design does.
module tb_trng_entropy_collector;

   localparam int NW = 16;

   logic clk = 1'b0;
   logic reset_n;
   logic enable;
   logic busy;
   logic rct_error;
   logic [NW*32-1:0] exp_block;
   int errors = 0;
   int checks = 0;

   trng_entropy_collector_if #(.NUM_WORDS(NW)) bus ();

   trng_entropy_collector #(
      .NUM_WORDS(NW),
      .RCT_LIMIT(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .busy(busy),
      .rct_error(rct_error),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one word and waits for its acknowledge, bounded to 8 cycles.
   task automatic feed(input logic [31:0] w, output bit ok);
      bus.src_data = w;
      bus.src_syn  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.src_ack === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL feed_ack: word %h got no src_ack in 8 cycles, required 1", w);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable = 1'b0;
      bus.src_syn = 1'b0;
      bus.src_data = '0;
      bus.block_ack = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.src_ack, bus.block_valid, busy, rct_error} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags: ack/valid/busy/rct=%b required 0000",
                  {bus.src_ack, bus.block_valid, busy, rct_error});
      end
      checks++;
      if (bus.block !== '0) begin
         errors++;
         $display("[TB] FAIL reset_block: got nonzero block, required 0");
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_block();
      bit ok;
      enable = 1'b1;
      exp_block = '0;
      for (int k = 1; k <= NW; k++) begin
         feed(32'(k), ok);
         exp_block = {exp_block[NW*32-33:0], 32'(k)};
         checks++;
         if (bus.block_valid !== (k == NW)) begin
            errors++;
            $display("[TB] FAIL basic_valid: after word %0d block_valid=%b required %b",
                     k, bus.block_valid, (k == NW));
         end
      end
      bus.src_syn = 1'b0;
      checks++;
      if (bus.block[511:480] !== 32'h0000_0001 || bus.block[31:0] !== 32'h0000_0010) begin
         errors++;
         $display("[TB] FAIL basic_ends: msw=%h lsw=%h required 00000001 00000010",
                  bus.block[511:480], bus.block[31:0]);
      end
      checks++;
      if (bus.block !== exp_block) begin
         errors++;
         $display("[TB] FAIL basic_block: block content differs from words 1..16");
      end
      tick();
      checks++;
      if (bus.src_ack !== 1'b0 || bus.block_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_pulse: ack=%b valid=%b required ack=0 valid=1",
                  bus.src_ack, bus.block_valid);
      end
   endtask

   task automatic test_hold_full();
      int bad = 0;
      bus.src_data = 32'hAAAA_0000;
      bus.src_syn  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.src_ack !== 1'b0 || bus.block_valid !== 1'b1 || bus.block !== exp_block) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL hold_full: %0d bad cycles while FULL, required 0", bad);
      end
      bus.block_ack = 1'b1;
      tick();
      bus.block_ack = 1'b0;
      checks++;
      if (bus.block_valid !== 1'b0 || bus.src_ack !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ack_release: valid=%b ack=%b busy=%b required 0 0 1",
                  bus.block_valid, bus.src_ack, busy);
      end
      tick();
      checks++;
      if (bus.src_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL resume_capture: src_ack=%b required 1", bus.src_ack);
      end
   endtask

   task automatic test_drop_enable();
      bit ok;
      for (int k = 1; k < 7; k++) begin
         feed(32'hAAAA_0000 + 32'(k), ok);
         if (k == 3) begin
            bus.block_ack = 1'b1;
            tick();
            bus.block_ack = 1'b0;
            checks++;
            if (bus.block_valid !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL stray_ack: valid=%b busy=%b required 0 1",
                        bus.block_valid, busy);
            end
         end
      end
      enable = 1'b0;
      bus.src_syn = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || bus.block_valid !== 1'b0 || bus.block !== '0) begin
         errors++;
         $display("[TB] FAIL drop_enable: busy=%b valid=%b block_zero=%b required 0 0 1",
                  busy, bus.block_valid, (bus.block == '0));
      end
      enable = 1'b1;
      exp_block = '0;
      for (int k = 0; k < NW; k++) begin
         feed(32'h0000_0100 + 32'(k), ok);
         exp_block = {exp_block[NW*32-33:0], 32'h0000_0100 + 32'(k)};
         checks++;
         if (bus.block_valid !== (k == NW - 1)) begin
            errors++;
            $display("[TB] FAIL refill_valid: after word %0d block_valid=%b required %b",
                     k + 1, bus.block_valid, (k == NW - 1));
         end
      end
      bus.src_syn = 1'b0;
      checks++;
      if (bus.block !== exp_block) begin
         errors++;
         $display("[TB] FAIL refill_block: block %h.. required %h..",
                  bus.block[511:480], exp_block[511:480]);
      end
   endtask

   task automatic test_enable_vs_ack();
      enable = 1'b0;
      bus.block_ack = 1'b1;
      tick();
      bus.block_ack = 1'b0;
      checks++;
      if (bus.block_valid !== 1'b0 || busy !== 1'b0 || bus.block !== '0) begin
         errors++;
         $display("[TB] FAIL enable_vs_ack: valid=%b busy=%b block_zero=%b required 0 0 1",
                  bus.block_valid, busy, (bus.block == '0));
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      enable = 1'b1;
      for (int k = 0; k < 3; k++) feed(32'h5000_0000 + 32'(k), ok);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.src_ack, bus.block_valid, busy, rct_error} !== 4'b0000 || bus.block !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset: ack/valid/busy/rct=%b block_zero=%b required 0000 1",
                  {bus.src_ack, bus.block_valid, busy, rct_error}, (bus.block == '0));
      end
      bus.src_syn = 1'b0;
      enable = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

`ifdef TRNG_ENTROPY_COLLECTOR_RCT_EN
   task automatic test_rct();
      bit ok;
      int bad = 0;
      enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         feed(32'h0102_0304, ok);
         checks++;
         if (rct_error !== (k == 4)) begin
            errors++;
            $display("[TB] FAIL rct_trip: after word %0d rct_error=%b required %b",
                     k, rct_error, (k == 4));
         end
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.src_ack !== 1'b0 || bus.block_valid !== 1'b0 || rct_error !== 1'b1 || busy !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL rct_halt: %0d bad cycles in ERROR, required 0", bad);
      end
      enable = 1'b0;
      bus.src_syn = 1'b0;
      tick();
      checks++;
      if (rct_error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rct_clear: rct_error=%b required 0", rct_error);
      end
   endtask
`else
   task automatic test_rct();
      bit ok;
      int bad = 0;
      enable = 1'b1;
      for (int k = 0; k < NW; k++) begin
         feed(32'h0102_0304, ok);
         if (rct_error !== 1'b0) bad++;
      end
      bus.src_syn = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL rct_off: rct_error high after %0d words, required 0", bad);
      end
      exp_block = {NW{32'h0102_0304}};
      checks++;
      if (bus.block_valid !== 1'b1 || bus.block !== exp_block) begin
         errors++;
         $display("[TB] FAIL const_block: valid=%b lsw=%h required 1 01020304",
                  bus.block_valid, bus.block[31:0]);
      end
      enable = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic_block();
      test_hold_full();
      test_drop_enable();
      test_enable_vs_ack();
      test_async_reset();
      test_rct();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
